// File: rtl/ycr_pipe_sleep_pkg.sv
// Shared definitions for the pipe-side sleep controller.
// Holds the WFI sequence state encoding and default timing constants.
package ycr_pipe_sleep_pkg;

  // WFI sequence states, 3-bit encoding
  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StDrain    = 3'd1,
    StSleepReq = 3'd2,
    StSleep    = 3'd3,
    StWake     = 3'd4,
    StSettle   = 3'd5
  } sleep_state_e;

  // Max cycles waiting for the pipe to go idle before WFI degrades to NOP
  localparam int unsigned DrainTmoDefault = 64;
  // Settle cycles after the clock enable returns before releasing the stall
  localparam int unsigned WakeDlyDefault  = 2;

endpackage

// File: rtl/ycr_pipe_sleep_ctrl.sv
// Pipe-side initiator of the clock-gating handshake.
// Runs the WFI sequence: stall, drain, request clock-off, wait for a wake
// event, request clock-on, settle, release. Runs on the always-on clock.
//
// Ports:
//   clk                      always-on core clock
//   rst_n                    synchronous active-low reset
//   wfi_req_i                1-cycle pulse, WFI reached commit
//   wfi_dis_i                WFI behaves as NOP
//   pipe_idle_i              no outstanding IMEM/DMEM transactions
//   irq_pend_i               enabled interrupt pending (level)
//   dbg_halt_req_i           debug halt request (level)
//   clkctl2pipe_clk_en_i     clock-enable feedback from clock controller
//   pipe2clkctl_sleep_req_o  clock disable request
//   pipe2clkctl_wake_req_o   clock enable request
//   wfi_stall_o              hold fetch/commit
//   wfi_sleep_o              status: pipe clock gated
//   wfi_done_o               1-cycle pulse, WFI retired
module ycr_pipe_sleep_ctrl
  import ycr_pipe_sleep_pkg::*;
#(
  parameter int unsigned DRAIN_TMO = DrainTmoDefault,
  parameter int unsigned WAKE_DLY  = WakeDlyDefault,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wfi_req_i,
  input  logic wfi_dis_i,
  input  logic pipe_idle_i,
  input  logic irq_pend_i,
  input  logic dbg_halt_req_i,
  input  logic clkctl2pipe_clk_en_i,
  output logic pipe2clkctl_sleep_req_o,
  output logic pipe2clkctl_wake_req_o,
  output logic wfi_stall_o,
  output logic wfi_sleep_o,
  output logic wfi_done_o
);

  localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_TMO);
  localparam logic [CNT_W-1:0] WakeLoad  = CNT_W'(WAKE_DLY);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  sleep_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             wake_evt;

  logic sleep_req_q, wake_req_q, stall_q, sleep_q, done_q;

  assign wake_evt = irq_pend_i | dbg_halt_req_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    // Shared down-counter, saturating at zero
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    unique case (state_q)
      StRun: begin
        if (wfi_req_i) begin
          if (wfi_dis_i || wake_evt) begin
            done_d = 1'b1;
          end else begin
            state_d = StDrain;
            cnt_d   = DrainLoad;
          end
        end
      end
      StDrain: begin
        // Wake beats idle; timeout retires the WFI as a NOP
        if (wake_evt) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else if (pipe_idle_i) begin
          state_d = StSleepReq;
        end else if ((DRAIN_TMO != 0) && (cnt_q == CntOne)) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      StSleepReq: begin
        if (wake_evt) begin
          state_d = StWake;
        end else if (!clkctl2pipe_clk_en_i) begin
          state_d = StSleep;
        end
      end
      StSleep: begin
        if (wake_evt) begin
          state_d = StWake;
        end
      end
      StWake: begin
        // Clock may still be on if the wake raced the sleep request
        if (clkctl2pipe_clk_en_i) begin
          if (WAKE_DLY == 0) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            state_d = StSettle;
            cnt_d   = WakeLoad;
          end
        end
      end
      StSettle: begin
        if (cnt_q <= CntOne) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      sleep_req_q <= 1'b0;
      wake_req_q  <= 1'b0;
      stall_q     <= 1'b0;
      sleep_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Outputs registered from the next state so they align with state_q
      sleep_req_q <= (state_d == StSleepReq) || (state_d == StSleep);
      wake_req_q  <= (state_d == StWake);
      stall_q     <= (state_d != StRun);
      sleep_q     <= (state_d == StSleep);
      done_q      <= done_d;
    end
  end

  assign pipe2clkctl_sleep_req_o = sleep_req_q;
  assign pipe2clkctl_wake_req_o  = wake_req_q;
  assign wfi_stall_o             = stall_q;
  assign wfi_sleep_o             = sleep_q;
  assign wfi_done_o              = done_q;

endmodule

// File: tb/tb_ycr_pipe_sleep_ctrl.sv
// Bench for ycr_pipe_sleep_ctrl with a small clock-controller model.
// Expected output traces are derived from event times of each scenario.
module tb_ycr_pipe_sleep_ctrl;

  localparam int WakeDly  = 2;
  localparam int DrainTmo = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wfi_req = 1'b0, wfi_dis = 1'b0, pipe_idle = 1'b0, irq = 1'b0, dbg = 1'b0;
  logic clk_en = 1'b1;
  logic sleep_req, wake_req, stall, wfi_sleep, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cc_lat = 0;
  int cc_cnt = 0;

  // Per-cycle trace: {stall, sleep_req, wake_req, wfi_sleep, done}
  logic [4:0] tr [0:8191];

  ycr_pipe_sleep_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .wfi_req_i               (wfi_req),
    .wfi_dis_i               (wfi_dis),
    .pipe_idle_i             (pipe_idle),
    .irq_pend_i              (irq),
    .dbg_halt_req_i          (dbg),
    .clkctl2pipe_clk_en_i    (clk_en),
    .pipe2clkctl_sleep_req_o (sleep_req),
    .pipe2clkctl_wake_req_o  (wake_req),
    .wfi_stall_o             (stall),
    .wfi_sleep_o             (wfi_sleep),
    .wfi_done_o              (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) tr[cyc % 8192] = {stall, sleep_req, wake_req, wfi_sleep, done};

  // Clock controller: toggles clk_en cc_lat cycles after a held request
  always @(posedge clk) begin
    if (!rst_n) begin
      clk_en <= 1'b1;
      cc_cnt <= 0;
    end else if (sleep_req && clk_en) begin
      if (cc_cnt >= cc_lat) begin
        clk_en <= 1'b0;
        cc_cnt <= 0;
      end else begin
        cc_cnt <= cc_cnt + 1;
      end
    end else if (wake_req && !clk_en) begin
      if (cc_cnt >= cc_lat) begin
        clk_en <= 1'b1;
        cc_cnt <= 0;
      end else begin
        cc_cnt <= cc_cnt + 1;
      end
    end else begin
      cc_cnt <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    total++;
    if ({stall, sleep_req, wake_req, wfi_sleep, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hold got=%b want=00000",
               {stall, sleep_req, wake_req, wfi_sleep, done});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      total++;
      if ({stall, sleep_req, wake_req, wfi_sleep, done} !== 5'b0) begin
        bad++;
        $display("FAIL reset_idle i=%0d got=%b want=00000", i,
                 {stall, sleep_req, wake_req, wfi_sleep, done});
      end
    end
    step();
  endtask

  // WFI as NOP: disabled, or a wake event already pending
  task automatic test_wfi_nop();
    for (int it = 0; it < 6; it++) begin
      int t0;
      int mode;
      logic [4:0] exp;
      mode = it % 3;
      t0 = cyc;
      wfi_dis = (mode == 0);
      irq     = (mode == 1);
      dbg     = (mode == 2);
      pipe_idle = 1'($urandom_range(0, 1));
      for (int k = t0; k <= t0 + 3; k++) begin
        wfi_req = (k == t0);
        step();
      end
      wfi_dis = 1'b0; irq = 1'b0; dbg = 1'b0; pipe_idle = 1'b0;
      for (int k = t0; k <= t0 + 3; k++) begin
        exp = {4'b0, (k == t0 + 1)};
        total++;
        if (tr[k % 8192] !== exp) begin
          bad++;
          $display("FAIL wfi_nop mode=%0d k=%0d got=%b want=%b", mode, k - t0,
                   tr[k % 8192], exp);
        end
      end
    end
  endtask

  task automatic test_sleep_wake(input int iters);
    for (int it = 0; it < iters; it++) begin
      int t0, d, g, l, p, s, r, last;
      logic [4:0] exp;
      l = $urandom_range(0, 3);
      d = $urandom_range(0, 6);
      g = $urandom_range(1, 12);
      if (it == 0) begin
        l = 1; d = 0; g = 10;
      end
      cc_lat = l;
      t0 = cyc;
      p = t0 + 1 + ((d > 1) ? d : 1);   // first SLEEP_REQ cycle
      s = p + 2 + l + g;                // irq driven during SLEEP
      r = s + 3 + l + WakeDly;          // back in RUN, done pulse
      last = r + 2;
      for (int k = t0; k <= last; k++) begin
        wfi_req   = (k == t0);
        pipe_idle = (k >= t0 + d);
        irq       = (k == s);
        step();
      end
      pipe_idle = 1'b0;
      for (int k = t0; k <= last; k++) begin
        exp = {(k >= t0 + 1 && k < r), (k >= p && k <= s), (k >= s + 1 && k <= s + 2 + l),
               (k >= p + 2 + l && k <= s), (k == r)};
        total++;
        if (tr[k % 8192] !== exp) begin
          bad++;
          $display("FAIL sleep_wake it=%0d lat=%0d k=%0d got=%b want=%b", it, l, k - t0,
                   tr[k % 8192], exp);
        end
      end
    end
  endtask

  task automatic test_drain_timeout();
    int t0, last;
    logic [4:0] exp;
    t0 = cyc;
    last = t0 + DrainTmo + 3;
    pipe_idle = 1'b0;
    for (int k = t0; k <= last; k++) begin
      // second pulse lands in DRAIN and must be ignored
      wfi_req = (k == t0) || (k == t0 + 10);
      step();
    end
    for (int k = t0; k <= last; k++) begin
      exp = {(k >= t0 + 1 && k <= t0 + DrainTmo), 3'b000, (k == t0 + DrainTmo + 1)};
      total++;
      if (tr[k % 8192] !== exp) begin
        bad++;
        $display("FAIL drain_timeout k=%0d got=%b want=%b", k - t0, tr[k % 8192], exp);
      end
    end
  endtask

  // irq arrives in the first SLEEP_REQ cycle
  task automatic test_race();
    for (int it = 0; it < 4; it++) begin
      int t0, d, l, p, r, wend, last;
      logic [4:0] exp;
      l = (it == 0) ? 0 : ((it == 1) ? 2 : $urandom_range(0, 3));
      d = $urandom_range(0, 4);
      cc_lat = l;
      t0 = cyc;
      p = t0 + 1 + ((d > 1) ? d : 1);
      wend = (l == 0) ? p + 2 : p + 1;
      r = wend + 1 + WakeDly;
      last = r + 2;
      for (int k = t0; k <= last; k++) begin
        wfi_req   = (k == t0);
        pipe_idle = (k >= t0 + d);
        irq       = (k == p);
        step();
      end
      pipe_idle = 1'b0;
      for (int k = t0; k <= last; k++) begin
        exp = {(k >= t0 + 1 && k < r), (k == p), (k >= p + 1 && k <= wend), 1'b0, (k == r)};
        total++;
        if (tr[k % 8192] !== exp) begin
          bad++;
          $display("FAIL race it=%0d lat=%0d k=%0d got=%b want=%b", it, l, k - t0,
                   tr[k % 8192], exp);
        end
      end
    end
  endtask

  // dbg halt and idle together in DRAIN: wake wins
  task automatic test_dbg_drain();
    for (int it = 0; it < 3; it++) begin
      int t0, d, last;
      logic [4:0] exp;
      d = $urandom_range(0, 5);
      t0 = cyc;
      last = t0 + d + 4;
      for (int k = t0; k <= last; k++) begin
        wfi_req   = (k == t0);
        dbg       = (k == t0 + 1 + d);
        pipe_idle = (k == t0 + 1 + d);
        step();
      end
      for (int k = t0; k <= last; k++) begin
        exp = {(k >= t0 + 1 && k <= t0 + 1 + d), 3'b000, (k == t0 + 2 + d)};
        total++;
        if (tr[k % 8192] !== exp) begin
          bad++;
          $display("FAIL dbg_drain d=%0d k=%0d got=%b want=%b", d, k - t0, tr[k % 8192], exp);
        end
      end
    end
  endtask

  task automatic test_reset_sleep();
    int t0, last;
    logic [4:0] exp;
    cc_lat = 0;
    t0 = cyc;
    last = t0 + 10;
    for (int k = t0; k <= last; k++) begin
      wfi_req   = (k == t0);
      pipe_idle = 1'b1;
      rst_n     = (k != t0 + 6);
      step();
    end
    pipe_idle = 1'b0;
    for (int k = t0; k <= last; k++) begin
      exp = {(k >= t0 + 1 && k <= t0 + 6), (k >= t0 + 2 && k <= t0 + 6), 1'b0,
             (k >= t0 + 4 && k <= t0 + 6), 1'b0};
      total++;
      if (tr[k % 8192] !== exp) begin
        bad++;
        $display("FAIL reset_sleep k=%0d got=%b want=%b", k - t0, tr[k % 8192], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wfi_nop();
    test_sleep_wake(6);
    test_drain_timeout();
    test_race();
    test_dbg_drain();
    test_reset_sleep();
    test_sleep_wake(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
